// File: rtl/alu_pkg.sv
// Shared types for the ALU result buffer: word width, the stored entry
// format and the controller state encoding.
// Optional feature macro: ALU_RESULT_PARITY_EN adds a parity bit to each entry.
package alu_pkg;

  localparam int WORD_W = 16;

  // One buffered result. The flags are computed once at push time, so the
  // head outputs come straight from storage with no logic after the register.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              zero;
    logic              neg;
`ifdef ALU_RESULT_PARITY_EN
    logic              parity;
`endif
  } entry_t;

  // The encoding doubles as the occupancy count driven on the port.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generator on the push path: zero, sign and (optionally)
// even parity of the incoming result word.
// Optional feature macro: ALU_RESULT_PARITY_EN enables the o_parity output.
module alu_flag_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_zero,
  output logic             o_neg
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic             o_parity
`endif
);

  // Flags are pure functions of the word.
  always_comb begin
    o_zero = (i_data == '0);
    o_neg  = i_data[WIDTH-1];
  end

`ifdef ALU_RESULT_PARITY_EN
  // XOR reduction: 1 when the word has an odd number of set bits.
  always_comb begin
    o_parity = ^i_data;
  end
`endif

endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry FIFO that decouples the ALU result mux from its consumer.
// Each entry carries the word and its precomputed flags; all head outputs and
// in_ready are driven from registered state only.
// Optional feature macro: ALU_RESULT_PARITY_EN adds the out_parity port.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  state_t r_state;
  state_t w_state_next;
  entry_t r_mem [0:1];
  logic   r_wptr;
  logic   r_rptr;

  logic   w_push;
  logic   w_pop;
  logic   w_zero;
  logic   w_neg;
  entry_t w_entry;
`ifdef ALU_RESULT_PARITY_EN
  logic   w_parity;
`endif

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .i_data   (in_data),
    .o_zero   (w_zero),
    .o_neg    (w_neg)
`ifdef ALU_RESULT_PARITY_EN
    ,
    .o_parity (w_parity)
`endif
  );

  // Handshakes and status, all derived from the registered state.
  always_comb begin
    in_ready  = (r_state != ST_FULL);
    out_valid = (r_state != ST_EMPTY);
    occupancy = r_state;
    w_push    = in_valid && in_ready;
    w_pop     = out_valid && out_ready;
  end

  // Assemble the entry to be stored from the incoming word and its flags.
  always_comb begin
    w_entry      = '0;
    w_entry.data = in_data;
    w_entry.zero = w_zero;
    w_entry.neg  = w_neg;
`ifdef ALU_RESULT_PARITY_EN
    w_entry.parity = w_parity;
`endif
  end

  // Controller next state: occupancy moves by push/pop, flush empties.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_push) w_state_next = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_next = ST_FULL;
        else if (w_pop && !w_push) w_state_next = ST_EMPTY;
      end
      ST_FULL:  if (w_pop) w_state_next = ST_ONE;
      default:  w_state_next = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_next = ST_EMPTY;
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Entry storage and 1-bit pointers; flush realigns both pointers to slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else if (flush) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
    end
  end

  // Head outputs are a register select only; they hold while stalled.
  always_comb begin
    out_data = r_mem[r_rptr].data;
    out_zero = r_mem[r_rptr].zero;
    out_neg  = r_mem[r_rptr].neg;
`ifdef ALU_RESULT_PARITY_EN
    out_parity = r_mem[r_rptr].parity;
`endif
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
// Optional feature macro: ALU_RESULT_PARITY_EN also checks out_parity.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int W = WORD_W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic [W-1:0] out_data;
  logic         out_zero;
  logic         out_neg;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   occupancy;
`ifdef ALU_RESULT_PARITY_EN
  logic         out_parity;
`endif

  alu_result_buffer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef ALU_RESULT_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the buffer contents, oldest first.
  logic [W-1:0] model_q[$];
  bit           model_known = 0;
  bit           fresh_reset = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] head;
    if (!model_known) return;
    check_eq("occupancy", 32'(occupancy), 32'(model_q.size()));
    check_eq("in_ready", 32'(in_ready), 32'(model_q.size() != 2));
    check_eq("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      head = model_q[0];
      check_eq("out_data", 32'(out_data), 32'(head));
      check_eq("out_zero", 32'(out_zero), 32'(head == 0));
      check_eq("out_neg", 32'(out_neg), 32'(head >= (1 << (W - 1))));
`ifdef ALU_RESULT_PARITY_EN
      begin
        int ones = 0;
        for (int b = 0; b < W; b++) ones += int'(head[b]);
        check_eq("out_parity", 32'(out_parity), 32'(ones % 2));
      end
`endif
    end else if (fresh_reset) begin
      check_eq("rst_out_data", 32'(out_data), 32'h0);
      check_eq("rst_out_zero", 32'(out_zero), 32'h0);
      check_eq("rst_out_neg", 32'(out_neg), 32'h0);
`ifdef ALU_RESULT_PARITY_EN
      check_eq("rst_out_parity", 32'(out_parity), 32'h0);
`endif
    end
  endtask

  // One clock cycle: apply inputs, check the current state, then advance
  // the model by the handshake rules.
  task automatic step(input bit r, input bit f, input bit v, input logic [W-1:0] d, input bit rdy);
    bit do_push;
    bit do_pop;
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
    check_outputs();
    do_push = v && (model_q.size() < 2);
    do_pop  = rdy && (model_q.size() != 0);
    @(posedge clk);
    #1;
    if (r) begin
      model_q.delete();
      model_known = 1;
      fresh_reset = 1;
    end else if (model_known) begin
      if (f) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          model_q.push_back(d);
          fresh_reset = 0;
        end
      end
    end
  endtask

  initial begin
    // Reset wins over a valid input word.
    step(1, 0, 1, 16'h1234, 0);
    step(0, 0, 0, 16'h0000, 1);

    // Single pass of a negative word.
    step(0, 0, 1, 16'h8000, 1);
    step(0, 0, 0, 16'h0000, 1);
    step(0, 0, 0, 16'h0000, 1);

    // Fill under backpressure; third word must be refused.
    step(0, 0, 1, 16'h0000, 0);
    step(0, 0, 1, 16'h00FF, 0);
    step(0, 0, 1, 16'h1111, 0);
    step(0, 0, 0, 16'h0000, 0);

    // Drain in order.
    step(0, 0, 0, 16'h0000, 1);
    step(0, 0, 0, 16'h0000, 1);
    step(0, 0, 0, 16'h0000, 1);

    // Concurrent push/pop at occupancy 1.
    step(0, 0, 1, 16'h0001, 0);
    step(0, 0, 1, 16'h0002, 1);
    step(0, 0, 0, 16'h0000, 0);

    // Flush while full with a push attempt, then flush overriding push+pop.
    step(0, 0, 1, 16'h0003, 0);
    step(0, 1, 1, 16'h0004, 0);
    step(0, 0, 1, 16'h0005, 0);
    step(0, 1, 1, 16'h0006, 1);
    step(0, 0, 0, 16'h0000, 0);

    // Parity words.
    step(0, 0, 1, 16'h0007, 1);
    step(0, 0, 1, 16'h0003, 1);
    step(0, 0, 0, 16'h0000, 1);

    // Mid-operation reset with handshake activity.
    step(0, 0, 1, 16'hABCD, 0);
    step(1, 0, 1, 16'h5555, 1);
    step(0, 0, 0, 16'h0000, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit           r;
      bit           f;
      bit           v;
      bit           rdy;
      logic [W-1:0] d;
      int           sel;
      r   = ($urandom_range(0, 199) == 0);
      f   = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 7);
      if (sel == 0)      d = '0;
      else if (sel == 1) d = 16'h8000;
      else               d = W'($urandom);
      step(r, f, v, d, rdy);
    end
    step(0, 0, 0, 16'h0000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
